alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Shares the single combinational 4-bit ALU (`tt_um_dcb277_ALU` datapath: operands A/B, 4-bit function code, 4-bit result Y) between two independent requesters. Each requester submits an operation over a valid/ready handshake. A round-robin arbiter grants one request at a time and drives the ALU inputs for a fixed settle window. The block then captures Y and returns it on a single tagged response channel. It sits between the command sources (host interface, test sequencer) and the ALU/7-segment path.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the ALU inputs are held stable before Y is captured. Legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1; `req0_ready` out 1; `req0_a` in 4; `req0_b` in 4; `req0_func` in 4: requester 0 command.
- `req1_valid` in 1; `req1_ready` out 1; `req1_a` in 4; `req1_b` in 4; `req1_func` in 4: requester 1 command.
- `alu_a` out 4; `alu_b` out 4; `alu_func` out 4: drive the ALU inputs.
- `alu_y` in 4: ALU result.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester that owns the response.
- `rsp_y` out 4: captured result.
- `rsp_err` out 1: illegal function code.
- `busy` out 1: high when state != IDLE.

## Operation
- **Legal func codes:** 0000 add, 0001 sub, 0100 and, 0101 or, 0110 xor, 1000 sll, 1001 srl, 1010 sra, 1111 pass. All other codes are illegal.
- **States:** IDLE, EXEC, RESP.
- **IDLE: readiness and grant.** `reqN_ready` is driven combinationally; only the granted requester sees ready=1.
  - Only one valid → grant it.
  - Both valid → grant the requester that is not `last_grant`.
- **IDLE: acceptance.** Acceptance is `valid && ready` at a rising edge. On acceptance:
  - Latch a, b, func and id.
  - Set `last_grant` := id.
  - Legal func → EXEC with counter := `SETTLE_CYCLES`-1.
  - Illegal func → RESP with `rsp_err`=1 and `rsp_y`=0. The ALU outputs are not updated.
- **EXEC.**
  - `alu_a`/`alu_b`/`alu_func` are driven from the latched operands.
  - The counter decrements each cycle.
  - On the edge where counter==0: `rsp_y` := `alu_y`, `rsp_err` := 0, go to RESP.
- **RESP.**
  - `rsp_valid`=1.
  - `rsp_id`, `rsp_y` and `rsp_err` are held stable until the handshake.
  - On the edge with `rsp_ready`=1 → IDLE.
- **Ready outside IDLE:** both `reqN_ready` are 0 in EXEC and RESP.
- **ALU outputs:** `alu_*` registers hold the last legal operation's operands in IDLE and RESP. They change only on a legal acceptance.
- **Arithmetic:** results are the ALU's 4-bit values (wrap-around modulo 16); the arbiter adds no width or sign logic.
- **Requester rules:**
  - A requester may deassert valid before it is granted; no state changes.
  - Operands are sampled only at acceptance.
  - `rsp_ready` is ignored outside RESP.
- **Reset** (any state, including mid-EXEC or RESP):
  - Next state is IDLE.
  - `last_grant`=1, so req0 wins the first tie.
  - All outputs 0: `rsp_valid`, `rsp_id`, `rsp_y`, `rsp_err`, `alu_a`, `alu_b`, `alu_func`, `busy`, `reqN_ready` (ready is combinational and becomes valid-dependent from the first cycle after reset).
  - An in-flight transaction is dropped with no response.

## Timing
- Accept at edge t0.
- EXEC occupies the cycles after edges t0 .. t0+`SETTLE_CYCLES`-1.
- Capture occurs at edge t0+`SETTLE_CYCLES`; `rsp_valid` is high from that edge.
- With `rsp_ready` tied high: response handshake at edge t0+`SETTLE_CYCLES`+1; next acceptance possible at edge t0+`SETTLE_CYCLES`+2.
- Peak throughput is one operation per `SETTLE_CYCLES`+2 cycles.
- Illegal func: `rsp_valid` from edge t0+1; peak throughput of 3 cycles per rejected command.
- No combinational path from `alu_y` or `reqN_*` operands to any output. Ready depends combinationally on `reqN_valid`, state and `last_grant` only.

## Test plan
- **Single add:** req0 add, A=2, B=0xE, `SETTLE_CYCLES`=2 → `rsp_valid` at accept+2, `rsp_y`=0x0, `rsp_id`=0, `rsp_err`=0, `alu_func`=0000 during EXEC.
- **Round-robin:** both requesters valid continuously; req0 sub A=2, B=4; req1 and A=6, B=6 → responses alternate `rsp_id`=0,1,0,1 with `rsp_y`=0xE, 0x6, 0xE, 0x6; req0 wins the first tie after reset.
- **Illegal func:** req1 func=0011 → `rsp_valid` one cycle after accept, `rsp_err`=1, `rsp_y`=0, `alu_a`/`alu_b`/`alu_func` unchanged from the previous operation.
- **Response backpressure:** `rsp_ready` held low 5 cycles in RESP → `rsp_valid`/`rsp_y`/`rsp_id` stable, both ready low, no acceptance; release → IDLE next cycle.
- **Reset mid-EXEC:** `rst` pulsed for one edge during EXEC → next cycle `busy`=0, `rsp_valid`=0, all registered outputs 0, no response ever issued for the dropped request.
- **`SETTLE_CYCLES`=1 build:** req0 sll A=3, B=1 → `rsp_y`=0x6 at accept+1; back-to-back req0 stream achieves one accept every 3 cycles.

Source files
------------

// File: rtl/alu_rr_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_rr_arbiter_if
//  Description : Command, ALU and response signals shared between the two
//                requesters, the arbiter and the ALU datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_rr_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req0_func;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic [3:0] req1_func;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_func;
    logic [3:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_y;
    logic       rsp_err;
    logic       busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_func,
        input  req1_valid, req1_a, req1_b, req1_func,
        input  alu_y, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_func,
        output rsp_valid, rsp_id, rsp_y, rsp_err, busy
    );

    // Requesters / ALU / response consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_func,
        output req1_valid, req1_a, req1_b, req1_func,
        output alu_y, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_func,
        input  rsp_valid, rsp_id, rsp_y, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_rr_arbiter
//  Description : Round-robin sharing of one combinational 4-bit ALU between
//                two valid/ready requesters, with a settle window before the
//                result is captured and returned on a tagged response.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_last_grant;
    logic [3:0] r_cnt;
    logic       r_illegal;
    logic       r_rsp_id;
    logic [3:0] r_rsp_y;
    logic       r_rsp_err;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_alu_func;

    logic       w_grant0;
    logic       w_grant1;
    logic       w_accept;
    logic       w_sel_id;
    logic [3:0] w_sel_a;
    logic [3:0] w_sel_b;
    logic [3:0] w_sel_func;
    logic       w_legal;

    function automatic logic is_legal(input logic [3:0] f);
        case (f)
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1111: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // A lone requester always wins; on a tie the one not granted last wins.
    assign w_grant0   = bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
    assign w_grant1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_accept   = (r_state == S_IDLE) && (w_grant0 || w_grant1);
    assign w_sel_id   = w_grant1;
    assign w_sel_a    = w_grant1 ? bus.req1_a    : bus.req0_a;
    assign w_sel_b    = w_grant1 ? bus.req1_b    : bus.req0_b;
    assign w_sel_func = w_grant1 ? bus.req1_func : bus.req0_func;
    assign w_legal    = is_legal(w_sel_func);

    assign bus.req0_ready = !rst && (r_state == S_IDLE) && w_grant0;
    assign bus.req1_ready = !rst && (r_state == S_IDLE) && w_grant1;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_func   = r_alu_func;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_y      = r_rsp_y;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; an illegal command still spends one cycle in EXEC so
    // its response appears one edge after acceptance.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_next = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0) w_state_next = S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Command latch, settle counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_illegal    <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_y      <= 4'd0;
            r_rsp_err    <= 1'b0;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_func   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_sel_id;
                        r_rsp_id     <= w_sel_id;
                        r_illegal    <= !w_legal;
                        if (w_legal) begin
                            r_alu_a    <= w_sel_a;
                            r_alu_b    <= w_sel_b;
                            r_alu_func <= w_sel_func;
                            r_cnt      <= c_CNT_INIT;
                        end else begin
                            r_cnt      <= 4'd0;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) begin
                        r_rsp_y   <= r_illegal ? 4'd0 : bus.alu_y;
                        r_rsp_err <= r_illegal;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rr_arbiter
//  Description : Directed self-checking bench for alu_rr_arbiter, with one
//                SETTLE_CYCLES=2 instance and one SETTLE_CYCLES=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_rr_arbiter_if b  ();
    alu_rr_arbiter_if b1 ();

    alu_rr_arbiter #(.SETTLE_CYCLES(2)) dut  (.clk(clk), .rst(rst), .bus(b));
    alu_rr_arbiter #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU feeding each arbiter.
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] bb,
                                             input logic [3:0] f);
        case (f)
            4'h0:    alu_model = a + bb;
            4'h1:    alu_model = a - bb;
            4'h4:    alu_model = a & bb;
            4'h5:    alu_model = a | bb;
            4'h6:    alu_model = a ^ bb;
            4'h8:    alu_model = a << bb;
            4'h9:    alu_model = a >> bb;
            4'hA:    alu_model = 4'($signed(a) >>> bb);
            4'hF:    alu_model = a;
            default: alu_model = 4'h0;
        endcase
    endfunction

    always_comb b.alu_y  = alu_model(b.alu_a,  b.alu_b,  b.alu_func);
    always_comb b1.alu_y = alu_model(b1.alu_a, b1.alu_b, b1.alu_func);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        b.req0_valid = 0; b.req0_a = 0; b.req0_b = 0; b.req0_func = 0;
        b.req1_valid = 0; b.req1_a = 0; b.req1_b = 0; b.req1_func = 0;
        b.rsp_ready  = 0;
        b1.req0_valid = 0; b1.req0_a = 0; b1.req0_b = 0; b1.req0_func = 0;
        b1.req1_valid = 0; b1.req1_a = 0; b1.req1_b = 0; b1.req1_func = 0;
        b1.rsp_ready  = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0;
        checks++;
        if ({b.busy, b.rsp_valid, b.rsp_id, b.rsp_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {b.busy, b.rsp_valid, b.rsp_id, b.rsp_err});
        end
        checks++;
        if ({b.rsp_y, b.alu_a, b.alu_b, b.alu_func} !== 16'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0000", {b.rsp_y, b.alu_a, b.alu_b, b.alu_func});
        end
        checks++;
        if ({b.req0_ready, b.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {b.req0_ready, b.req1_ready});
        end
        b.req1_valid = 1; #1;
        checks++;
        if ({b.req0_ready, b.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_ready_follows_valid: got %b expected 01", {b.req0_ready, b.req1_ready});
        end
        b.req1_valid = 0; #1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_y;
        int n;
        b.rsp_ready = 1;
        b.req0_valid = 1; b.req0_a = 4'h2; b.req0_b = 4'h4; b.req0_func = 4'h1;
        b.req1_valid = 1; b.req1_a = 4'h6; b.req1_b = 4'h6; b.req1_func = 4'h4;
        #1;
        checks++;
        if ({b.req0_ready, b.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rr_first_tie: got %b expected 10", {b.req0_ready, b.req1_ready});
        end
        for (int k = 0; k < 4; k++) begin
            exp_y = (k % 2 == 0) ? 4'hE : 4'h6;
            n = 0;
            while (!b.rsp_valid && n < 20) begin tick(); n++; end
            checks++;
            if (n >= 20) begin
                errors++; $display("FAIL rr_timeout: got no response %0d expected response", k);
            end else if (b.rsp_id !== 1'(k % 2) || b.rsp_y !== exp_y || b.rsp_err !== 1'b0) begin
                errors++; $display("FAIL rr_rsp%0d: got id=%b y=%h err=%b expected id=%0d y=%h err=0",
                                   k, b.rsp_id, b.rsp_y, b.rsp_err, k % 2, exp_y);
            end
            tick();
        end
        b.req0_valid = 0; b.req1_valid = 0; b.rsp_ready = 0;
    endtask

    task automatic test_single_add();
        b.req0_valid = 1; b.req0_a = 4'h2; b.req0_b = 4'hE; b.req0_func = 4'h0;
        #1;
        checks++;
        if (b.req0_ready !== 1'b1) begin
            errors++; $display("FAIL add_ready: got %b expected 1", b.req0_ready);
        end
        tick();
        b.req0_valid = 0;
        checks++;
        if ({b.busy, b.rsp_valid, b.alu_a, b.alu_b, b.alu_func} !== {2'b10, 12'h2E0}) begin
            errors++; $display("FAIL add_exec: got busy=%b vld=%b alu=%h%h%h expected busy=1 vld=0 alu=2e0",
                               b.busy, b.rsp_valid, b.alu_a, b.alu_b, b.alu_func);
        end
        tick();
        checks++;
        if (b.rsp_valid !== 1'b0 || b.alu_func !== 4'h0) begin
            errors++; $display("FAIL add_exec2: got vld=%b func=%h expected vld=0 func=0", b.rsp_valid, b.alu_func);
        end
        tick();
        checks++;
        if ({b.rsp_valid, b.rsp_y, b.rsp_id, b.rsp_err} !== {1'b1, 4'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_rsp: got vld=%b y=%h id=%b err=%b expected vld=1 y=0 id=0 err=0",
                               b.rsp_valid, b.rsp_y, b.rsp_id, b.rsp_err);
        end
        b.rsp_ready = 1; tick(); b.rsp_ready = 0;
        checks++;
        if (b.busy !== 1'b0) begin
            errors++; $display("FAIL add_idle: got busy=%b expected 0", b.busy);
        end
    endtask

    task automatic test_illegal();
        b.req1_valid = 1; b.req1_a = 4'h9; b.req1_b = 4'h9; b.req1_func = 4'b0011;
        tick();
        b.req1_valid = 0;
        checks++;
        if (b.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL ill_early: got vld=%b expected 0", b.rsp_valid);
        end
        tick();
        checks++;
        if ({b.rsp_valid, b.rsp_err, b.rsp_y, b.rsp_id} !== {1'b1, 1'b1, 4'h0, 1'b1}) begin
            errors++; $display("FAIL ill_rsp: got vld=%b err=%b y=%h id=%b expected vld=1 err=1 y=0 id=1",
                               b.rsp_valid, b.rsp_err, b.rsp_y, b.rsp_id);
        end
        checks++;
        if ({b.alu_a, b.alu_b, b.alu_func} !== 12'h2E0) begin
            errors++; $display("FAIL ill_alu_hold: got %h%h%h expected 2e0", b.alu_a, b.alu_b, b.alu_func);
        end
        b.rsp_ready = 1; tick(); b.rsp_ready = 0;
    endtask

    task automatic test_backpressure();
        b.req0_valid = 1; b.req0_a = 4'h5; b.req0_b = 4'h3; b.req0_func = 4'h6;
        b.req1_valid = 1; b.req1_a = 4'h6; b.req1_b = 4'h6; b.req1_func = 4'h4;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({b.rsp_valid, b.rsp_y, b.rsp_id, b.req0_ready, b.req1_ready, b.alu_func} !==
                {1'b1, 4'h6, 1'b0, 2'b00, 4'h6}) begin
                errors++; $display("FAIL bp_hold%0d: got vld=%b y=%h id=%b rdy=%b%b func=%h expected vld=1 y=6 id=0 rdy=00 func=6",
                                   i, b.rsp_valid, b.rsp_y, b.rsp_id, b.req0_ready, b.req1_ready, b.alu_func);
            end
            tick();
        end
        b.rsp_ready = 1; tick();
        b.req0_valid = 0; b.req1_valid = 0; b.rsp_ready = 0;
        checks++;
        if ({b.busy, b.rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL bp_release: got busy=%b vld=%b expected 0 0", b.busy, b.rsp_valid);
        end
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        b.rsp_ready = 1;
        b.req0_valid = 1; b.req0_a = 4'h1; b.req0_b = 4'h1; b.req0_func = 4'h0;
        tick();
        b.req0_valid = 0;
        checks++;
        if ({b.busy, b.alu_a} !== {1'b1, 4'h1}) begin
            errors++; $display("FAIL rme_exec: got busy=%b a=%h expected busy=1 a=1", b.busy, b.alu_a);
        end
        rst = 1; tick(); rst = 0;
        checks++;
        if ({b.busy, b.rsp_valid, b.rsp_id, b.rsp_err, b.rsp_y, b.alu_a, b.alu_b, b.alu_func} !== 20'h0) begin
            errors++; $display("FAIL rme_cleared: got busy=%b vld=%b id=%b err=%b y=%h alu=%h%h%h expected all 0",
                               b.busy, b.rsp_valid, b.rsp_id, b.rsp_err, b.rsp_y, b.alu_a, b.alu_b, b.alu_func);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (b.rsp_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rme_no_rsp: got %0d response cycles expected 0", seen);
        end
        b.rsp_ready = 0;
    endtask

    task automatic test_back_to_back();
        int acc[8];
        int n_acc;
        int first_rsp;
        logic [3:0] y_at_first;
        n_acc = 0; first_rsp = -1; y_at_first = 4'hX;
        b1.rsp_ready = 1;
        b1.req0_valid = 1; b1.req0_a = 4'h3; b1.req0_b = 4'h1; b1.req0_func = 4'h8;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (b1.req0_ready && n_acc < 8) begin acc[n_acc] = c; n_acc++; end
            tick();
            if (b1.rsp_valid && first_rsp < 0) begin first_rsp = c; y_at_first = b1.rsp_y; end
        end
        b1.req0_valid = 0;
        checks++;
        if (n_acc !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d accepts expected 4", n_acc);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc[i] - acc[i-1] !== 3) begin
                    errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected 3", i, acc[i] - acc[i-1]);
                end
            end
            checks++;
            if (first_rsp !== acc[0] + 1 || y_at_first !== 4'h6) begin
                errors++; $display("FAIL s1_sll: got edge=%0d y=%h expected edge=%0d y=6",
                                   first_rsp, y_at_first, acc[0] + 1);
            end
        end
        tick(); tick();
        b1.rsp_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_single_add();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
